// File: rtl/dec_lut_req_arbiter.sv
// dec_lut_req_arbiter: round-robin share of one LUT decoder among N_REQ requesters (req_valid/req_w/req_ready in, dec_w/dec_found/dec_n decoder side, rsp_* out tagged by id); DEC_LUT_ARB_STATS_EN enables stat_done/stat_tmo counters
module dec_lut_req_arbiter #(
  parameter int N_REQ     = 4,
  parameter int W_BITS    = 30,
  parameter int N_BITS    = 17,
  parameter int BLANK_CYC = 2,
  parameter int TIMEOUT   = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*W_BITS-1:0]    req_w,
  output logic [N_REQ-1:0]           req_ready,
  output logic [W_BITS-1:0]          dec_w,
  input  logic                       dec_found,
  input  logic [N_BITS-1:0]          dec_n,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [N_BITS-1:0]          rsp_n,
  output logic                       rsp_err,
  output logic [15:0]                stat_done,
  output logic [15:0]                stat_tmo
);
  localparam int ID_W = $clog2(N_REQ);
  localparam int BW   = BLANK_CYC > 1 ? $clog2(BLANK_CYC) : 1;
  localparam int TW   = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, BLANK, WAIT, RESP} state_t;
  state_t            state_q, state_d;
  logic [ID_W-1:0]   last_q, last_d, rsp_id_q, rsp_id_d, win;
  logic              any;
  logic [W_BITS-1:0] dec_w_q, dec_w_d;
  logic [N_BITS-1:0] rsp_n_q, rsp_n_d;
  logic              rsp_err_q, rsp_err_d;
  logic [BW-1:0]     blank_q, blank_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  always_comb begin
    any = 1'b0;
    win = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req_valid[(int'(last_q) + k) % N_REQ]) begin
        any = 1'b1;
        win = ID_W'((int'(last_q) + k) % N_REQ);
      end
    end
  end
  assign req_ready = (state_q == IDLE && any) ? N_REQ'(1) << win : '0;
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    dec_w_d   = dec_w_q;
    rsp_id_d  = rsp_id_q;
    rsp_n_d   = rsp_n_q;
    rsp_err_d = rsp_err_q;
    blank_d   = blank_q;
    tmo_d     = tmo_q;
    case (state_q)
      IDLE: if (any) begin
        state_d  = BLANK;
        dec_w_d  = req_w[win*W_BITS +: W_BITS];
        rsp_id_d = win;
        last_d   = win;
        blank_d  = '0;
      end
      BLANK: if (blank_q == BW'(BLANK_CYC - 1)) begin
        state_d = WAIT;
        tmo_d   = '0;
      end else begin
        blank_d = blank_q + 1'b1;
      end
      WAIT: if (dec_found) begin
        rsp_n_d   = dec_n;
        rsp_err_d = 1'b0;
        state_d   = RESP;
      end else if (tmo_q == TW'(TIMEOUT - 1)) begin
        rsp_n_d   = '0;
        rsp_err_d = 1'b1;
        state_d   = RESP;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= ID_W'(N_REQ - 1);
      dec_w_q   <= '0;
      rsp_id_q  <= '0;
      rsp_n_q   <= '0;
      rsp_err_q <= 1'b0;
      blank_q   <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      dec_w_q   <= dec_w_d;
      rsp_id_q  <= rsp_id_d;
      rsp_n_q   <= rsp_n_d;
      rsp_err_q <= rsp_err_d;
      blank_q   <= blank_d;
      tmo_q     <= tmo_d;
    end
  end
  assign dec_w     = dec_w_q;
  assign rsp_valid = state_q == RESP;
  assign rsp_id    = rsp_id_q;
  assign rsp_n     = rsp_n_q;
  assign rsp_err   = rsp_err_q;
`ifdef DEC_LUT_ARB_STATS_EN
  logic        rsp_hs;
  logic [15:0] stat_done_q, stat_done_d, stat_tmo_q, stat_tmo_d;
  assign rsp_hs = state_q == RESP && rsp_ready;
  always_comb begin
    stat_done_d = (rsp_hs && !rsp_err_q && ~&stat_done_q) ? stat_done_q + 16'd1 : stat_done_q;
    stat_tmo_d  = (rsp_hs && rsp_err_q && ~&stat_tmo_q) ? stat_tmo_q + 16'd1 : stat_tmo_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_done_q <= '0;
      stat_tmo_q  <= '0;
    end else begin
      stat_done_q <= stat_done_d;
      stat_tmo_q  <= stat_tmo_d;
    end
  end
  assign stat_done = stat_done_q;
  assign stat_tmo  = stat_tmo_q;
`else
  assign stat_done = '0;
  assign stat_tmo  = '0;
`endif
endmodule

// File: tb/tb_dec_lut_req_arbiter.sv
// tb_dec_lut_req_arbiter: randomized scoreboard bench for dec_lut_req_arbiter with a latency-2 LUT decoder model
module tb_dec_lut_req_arbiter;
  localparam int N = 4, W = 30, NB = 17, BL = 2, TO = 16;
  logic            clk = 1'b0, rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*W-1:0]  req_w = '0;
  logic [N-1:0]    req_ready;
  logic [W-1:0]    dec_w;
  logic            dec_found;
  logic [NB-1:0]   dec_n;
  logic            rsp_valid, rsp_ready = 1'b0;
  logic [1:0]      rsp_id;
  logic [NB-1:0]   rsp_n;
  logic            rsp_err;
  logic [15:0]     stat_done, stat_tmo;
  typedef struct { int id; logic [NB-1:0] n; logic err; int acc; } exp_t;
  exp_t          q[$];
  int            glog[$];
  int            nvec = 0, nerr = 0, cyc = 0, ref_last = N - 1, ok_cnt = 0, tmo_cnt = 0, rdy_mode = 1;
  bit            busy = 1'b0;
  logic [W-1:0]  d1 = '0, d2 = '0;
  logic [N-1:0]  vld = '0;
  logic [W-1:0]  cw[N];

  dec_lut_req_arbiter #(.N_REQ(N), .W_BITS(W), .N_BITS(NB), .BLANK_CYC(BL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_w(req_w), .req_ready(req_ready),
    .dec_w(dec_w), .dec_found(dec_found), .dec_n(dec_n),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_n(rsp_n), .rsp_err(rsp_err),
    .stat_done(stat_done), .stat_tmo(stat_tmo));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    d1  <= dec_w;
    d2  <= d1;
  end
  assign dec_found = |d2[3:0];
  assign dec_n     = d2[20:4];

  function automatic logic lut_found(logic [W-1:0] c);
    return |c[3:0];
  endfunction
  function automatic logic [NB-1:0] lut_n(logic [W-1:0] c);
    return c[20:4];
  endfunction
  function automatic logic [W-1:0] gen_w(int miss);
    logic [W-1:0] x;
    x = W'($urandom);
    if ($urandom_range(99) < miss) x[3:0] = 4'h0;
    else if (x[3:0] == 4'h0) x[0] = 1'b1;
    return x;
  endfunction

  task automatic chk(string nm, longint act, longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) req_w[i*W +: W] = cw[i];
    req_valid = vld;
  endtask

  task automatic step(int p, int miss);
    logic [N-1:0] e;
    int win;
    exp_t x;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (!vld[i] && $urandom_range(99) < p) begin
        vld[i] = 1'b1;
        cw[i]  = gen_w(miss);
      end else if (vld[i] && p > 0 && p < 100 && $urandom_range(31) == 0) begin
        vld[i] = 1'b0;
      end
    end
    drive();
    #1;
    e = '0;
    win = -1;
    if (!busy)
      for (int k = 1; k <= N; k++)
        if (win < 0 && vld[(ref_last + k) % N]) win = (ref_last + k) % N;
    if (win >= 0) e[win] = 1'b1;
    chk("req_ready", req_ready, e);
    if (win >= 0) begin
      x.id  = win;
      x.err = !lut_found(cw[win]);
      x.n   = x.err ? '0 : lut_n(cw[win]);
      x.acc = cyc + 1;
      q.push_back(x);
      glog.push_back(win);
      ref_last = win;
      busy = 1'b1;
      vld[win] = 1'b0;
    end
  endtask

  task automatic wait_idle(bit drop);
    int g;
    if (drop) vld = '0;
    g = 0;
    while ((vld != '0 || busy || q.size() != 0) && g < 500) begin
      step(0, 0);
      g++;
    end
    if (g >= 500) chk("drain_timeout", 1, 0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    vld = '0;
    drive();
    q.delete();
    busy = 1'b0;
    ref_last = N - 1;
    ok_cnt = 0;
    tmo_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_dec_w", dec_w, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_n", rsp_n, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_stat_done", stat_done, 0);
    chk("rst_stat_tmo", stat_tmo, 0);
  endtask

  initial begin : monitor
    exp_t cur;
    bit have;
    have = 1'b0;
    forever begin
      @(negedge clk);
      rsp_ready = rdy_mode == 1 ? 1'b1 : rdy_mode == 2 ? 1'b0 : ($urandom_range(3) != 0);
      #1;
      if (rst) begin
        have = 1'b0;
        continue;
      end
      if (!rsp_valid) begin
        if (have) chk("rsp_valid_dropped", 0, 1);
        have = 1'b0;
        continue;
      end
      if (!have) begin
        if (q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
          continue;
        end
        cur = q[0];
        have = 1'b1;
        chk("rsp_latency", cyc - cur.acc, cur.err ? BL + TO : BL + 1);
      end
      chk("rsp_id", rsp_id, cur.id);
      chk("rsp_n", rsp_n, cur.n);
      chk("rsp_err", rsp_err, cur.err);
      if (rsp_ready) begin
        void'(q.pop_front());
        if (cur.err) tmo_cnt++;
        else ok_cnt++;
        have = 1'b0;
        @(posedge clk);
        busy = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int g;
    for (int i = 0; i < N; i++) cw[i] = '0;
    reset_dut();
    glog.delete();
    g = 0;
    while (glog.size() < 8 && g < 400) begin
      step(100, 0);
      g++;
    end
    for (int i = 0; i < 8; i++) chk("rr_order", i < glog.size() ? glog[i] : -1, i % N);
    wait_idle(1'b1);
    vld[0] = 1'b1;
    cw[0] = 30'h000FFFF1;
    wait_idle(1'b0);
    vld[1] = 1'b1;
    cw[1] = gen_w(0);
    vld[2] = 1'b1;
    cw[2] = gen_w(0);
    while (cw[2][20:4] == cw[1][20:4]) cw[2] = gen_w(0);
    wait_idle(1'b0);
    vld[3] = 1'b1;
    cw[3] = 30'h12345670;
    wait_idle(1'b0);
    vld[0] = 1'b1;
    cw[0] = gen_w(0);
    wait_idle(1'b0);
    rdy_mode = 2;
    vld[1] = 1'b1;
    cw[1] = gen_w(0);
    repeat (BL + 12) step(0, 0);
    rdy_mode = 1;
    wait_idle(1'b0);
    vld[2] = 1'b1;
    cw[2] = 30'h02AAAAA0;
    g = 0;
    while (!busy && g < 20) begin
      step(0, 0);
      g++;
    end
    repeat (BL + 2) step(0, 0);
    reset_dut();
    for (int i = 0; i < N; i++) begin
      vld[i] = 1'b1;
      cw[i] = gen_w(0);
    end
    glog.delete();
    step(0, 0);
    chk("first_grant_after_rst", glog.size() > 0 ? glog[0] : -1, 0);
    wait_idle(1'b1);
    rdy_mode = 0;
    repeat (600) step(30, 20);
    wait_idle(1'b1);
    @(negedge clk);
    #1;
`ifdef DEC_LUT_ARB_STATS_EN
    chk("stat_done", stat_done, ok_cnt);
    chk("stat_tmo", stat_tmo, tmo_cnt);
`else
    chk("stat_done_off", stat_done, 0);
    chk("stat_tmo_off", stat_tmo, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
